// File: rtl/shift_seq.sv
// Sequential barrel-less shifter: one bit position per clock, zero-fill by default.
// Optional rotate mode (extra rot port) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMTW-1:0]  amt,
  input  logic             dir,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AMTW-1:0]   count_q, count_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  out_d;
  logic [WIDTH-1:0]  step;
  logic              fill_l, fill_r;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q, rot_d;

  always_comb begin
    fill_l = rot_q & out[WIDTH-1];
    fill_r = rot_q & out[0];
  end
`else
  always_comb begin
    fill_l = 1'b0;
    fill_r = 1'b0;
  end
`endif

  always_comb begin
    step = dir_q ? {fill_r, out[WIDTH-1:1]} : {out[WIDTH-2:0], fill_l};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    out_d   = out;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !clr) begin
          out_d   = in;
          dir_d   = dir;
          count_d = amt;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d   = rot;
`endif
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // The step still lands on an aborting edge; clr only redirects state.
        out_d   = step;
        count_d = count_q - AMTW'(1);
        if (count_q == AMTW'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      out     <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      out     <= out_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: transaction-level reference model checked every cycle,
// directed literal cases, then randomized start/clr traffic.
module tb_shift_seq;
  localparam int W = 16;
  localparam int A = 4;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in_v = '0;
  logic [A-1:0] amt = '0;
  logic         dir = 1'b0;
  logic         rot = 1'b0;
  logic         clr = 1'b0;
  logic         busy, done;
  logic [W-1:0] out;

  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_on = 1'b0;

  always #5 clk = ~clk;

  shift_seq #(.WIDTH(W), .AMTW(A)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in   (in_v),
    .amt  (amt),
    .dir  (dir),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot  (rot),
`endif
    .clr  (clr),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  // Reference: an operation accepted at edge 0 is in cycle t after t-1 more edges;
  // out in cycle t is the operand moved by min(t-1, amt) positions.
  bit           m_act = 1'b0;
  int           m_t = 0;
  int           m_amt = 0;
  logic [W-1:0] m_in = '0;
  logic [W-1:0] m_out = '0;
  bit           m_dir = 1'b0;
  bit           m_rot = 1'b0;

  function automatic logic [W-1:0] shifted(logic [W-1:0] v, int s, bit d, bit r);
    int k;
    if (!r) begin
      if (s >= W) return '0;
      return d ? (v >> s) : (v << s);
    end
    k = s % W;
    if (k == 0) return v;
    return d ? ((v >> k) | (v << (W - k))) : ((v << k) | (v >> (W - k)));
  endfunction

  function automatic logic [W-1:0] exp_out();
    if (!m_act) return m_out;
    return shifted(m_in, (m_t - 1 < m_amt) ? m_t - 1 : m_amt, m_dir, m_rot);
  endfunction

  function automatic bit exp_done();
    return m_act && (m_t == m_amt + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_t   = 0;
      m_out = '0;
    end else if (m_act) begin
      if (clr) begin
        m_out = shifted(m_in, (m_t < m_amt) ? m_t : m_amt, m_dir, m_rot);
        m_act = 1'b0;
      end else if (m_t == m_amt + 1) begin
        m_out = shifted(m_in, m_amt, m_dir, m_rot);
        m_act = 1'b0;
      end else begin
        m_t++;
      end
    end else if (start && !clr) begin
      m_act = 1'b1;
      m_t   = 1;
      m_in  = in_v;
      m_amt = int'(amt);
      m_dir = dir;
      m_rot = ROT_EN && rot;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("busy", W'(busy), W'(m_act));
      chk("done", W'(done), W'(exp_done()));
      chk("out", out, exp_out());
    end
  end

  task automatic do_op(input logic [W-1:0] i, input int a, input bit d, input bit r,
                       output int lat);
    @(negedge clk);
    in_v = i; amt = A'(a); dir = d; rot = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_v = W'($urandom); amt = A'($urandom); dir = 1'($urandom); rot = 1'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    logic [W-1:0] exp_rot;

    @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_out", out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    do_op(16'h00F1, 4, 1'b0, 1'b0, lat);
    chk("left_latency", W'(lat), W'(5));
    chk("left_out", out, 16'h0F10);
    chk("left_model", exp_out(), 16'h0F10);
    @(negedge clk);
    chk("left_busy_after", W'(busy), '0);

    do_op(16'h8001, 15, 1'b1, 1'b0, lat);
    chk("right_latency", W'(lat), W'(16));
    chk("right_out", out, 16'h0001);
    chk("right_model", exp_out(), 16'h0001);

    do_op(16'hABCD, 0, 1'b0, 1'b0, lat);
    chk("zero_latency", W'(lat), W'(1));
    chk("zero_out", out, 16'hABCD);
    in_v = 16'h1234; amt = 4'd3; dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(20, cnt);
    chk("ignored_start_done", W'(cnt), '0);
    chk("ignored_start_out", out, 16'hABCD);

    @(negedge clk);
    in_v = 16'hFFFF; amt = 4'd8; dir = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_busy", W'(busy), '0);
    chk("abort_out", out, 16'hFFF8);
    chk("abort_model", exp_out(), 16'hFFF8);
    count_done(12, cnt);
    chk("abort_no_done", W'(cnt), '0);
    do_op(16'h0001, 2, 1'b0, 1'b0, lat);
    chk("after_abort_latency", W'(lat), W'(3));
    chk("after_abort_out", out, 16'h0004);

    exp_rot = ROT_EN ? 16'h0003 : 16'h0002;
    do_op(16'h8001, 1, 1'b0, 1'b1, lat);
    chk("rot1_latency", W'(lat), W'(2));
    chk("rot1_out", out, exp_rot);
    do_op(16'h8001, 1, 1'b0, 1'b0, lat);
    chk("rot0_out", out, 16'h0002);

    @(negedge clk);
    in_v = 16'h1234; amt = 4'd10; dir = 1'b0; rot = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", W'(busy), '0);
    chk("async_reset_done", W'(done), '0);
    chk("async_reset_out", out, '0);
    count_done(2, cnt);
    chk("reset_hold_done", W'(cnt), '0);
    rst_n = 1'b1;
    in_v = 16'h00F0; amt = 4'd1; dir = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_reset_accept", W'(busy), W'(1));
    @(negedge clk);
    chk("post_reset_done", W'(done), W'(1));
    chk("post_reset_out", out, 16'h0078);
    count_done(15, cnt);
    chk("post_reset_no_stale_done", W'(cnt), '0);

    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      in_v  = W'($urandom);
      amt   = A'($urandom);
      dir   = 1'($urandom);
      rot   = 1'($urandom);
      clr   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Parameter: AMTW, 4, shift-amount width in bits; the maximum shift is 2^AMTW-1.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request a new shift; sampled only in IDLE.
REQ-006 Port: in  input  WIDTH  operand; captured on an accepted start.
REQ-007 Port: amt  input  AMTW  number of bit positions; captured on an accepted start.
REQ-008 Port: dir  input  1  0 = left shift, 1 = right shift; captured on an accepted start.
REQ-009 Port: clr  input  1  synchronous abort; returns the block to IDLE.
REQ-010 Port: busy  output  1  high while in SHIFT or DONE.
REQ-011 Port: done  output  1  one-cycle pulse indicating that out is valid.
REQ-012 Port: out  output  WIDTH  result register; holds its value until the next accepted start.

Function
REQ-013 The block shall implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 and clr=0, the block shall capture in, amt and dir into registers and load out<=in.
- If amt=0, it goes to DONE.
- Otherwise it goes to SHIFT with count<=amt.
REQ-015 In SHIFT, each cycle the block shall apply exactly one 1-bit shift to out in the captured direction and decrement count. It goes to DONE on the cycle that count reaches 0.
REQ-016 Zero-fill rules: a left shift shall zero-fill bit 0 and discard bit WIDTH-1; a right shift shall zero-fill bit WIDTH-1 and discard bit 0.
REQ-017 In DONE, the block shall assert done for exactly one cycle and return to IDLE on the next edge.
REQ-018 Latency: done shall assert in cycle amt+1 after the start-accept edge; amt=0 gives 1 cycle and amt=15 gives 16 cycles.
REQ-019 A start asserted while busy=1 shall be ignored and shall not be queued.
REQ-020 clr=1 in any state shall force IDLE on the next edge.
- done and busy drop to 0.
- out keeps its partial value.
- clr has priority over start in the same cycle.
REQ-021 Back-to-back operation: start asserted in the IDLE cycle immediately after DONE shall be accepted, giving a minimum issue interval of amt+2 cycles.
REQ-022 Changes on in, amt or dir after acceptance shall not affect the operation in flight.
REQ-023 Shift counts with amt >= WIDTH cannot occur at the defaults; if parameters allow them, the result shall be all zeros (non-rotate mode).

Reset
REQ-024 rst_n=0 shall immediately, without waiting for clk, set:
- state=IDLE
- count=0
- out=0
- busy=0
- done=0
REQ-025 Reset asserted mid-operation shall abandon the operation with no done pulse. After rst_n deasserts, the first rising edge shall be able to accept start.

Configuration
REQ-026 Macro SHIFT_SEQ_ROTATE_EN shall control a rotate mode.
REQ-027 When SHIFT_SEQ_ROTATE_EN is defined:
- The block shall add port rot  input  1, captured on an accepted start.
- When rot=1, each SHIFT step shall wrap the discarded bit into the vacated position (rotate left or right).
- Latency shall be unchanged.
REQ-028 When SHIFT_SEQ_ROTATE_EN is undefined, the rot port shall be absent and the block shall behave only as the zero-fill shifter.

Verification
REQ-029 Reset test: rst_n=0 asynchronously mid-SHIFT -> out=0, busy=0 and done=0 before the next clk edge, with no done pulse afterwards.
REQ-030 Left shift test: in=16'h00F1, amt=4, dir=0 -> done in cycle 5, out=16'h0F10, busy high for cycles 1-5.
REQ-031 Right shift test: in=16'h8001, amt=15, dir=1 -> done in cycle 16, out=16'h0001.
REQ-032 Zero and ignored-start test: in=16'hABCD, amt=0 -> done in cycle 1, out=16'hABCD. A second start issued while busy is ignored, with no second done.
REQ-033 Abort test: in=16'hFFFF, amt=8, dir=0 with clr=1 in cycle 3 -> IDLE in cycle 4, no done pulse, out=16'hFFF8, and the next start is accepted normally.
REQ-034 Rotate test (SHIFT_SEQ_ROTATE_EN defined): in=16'h8001, amt=1, dir=0, rot=1 -> out=16'h0003; the same stimulus with rot=0 -> out=16'h0002.
